hit_judge: RTL and testbench
============================

// Module: hit_judge
// PURPOSE
//  Beat-grid consumer for the DDR game. Tracks the four arrow lanes (0=L,1=D,2=U,3=R).
//  Arms a hit window for each note that reaches the target line, counting tick_i pulses.
//  Grades the player's rising button edges as PERFECT, GOOD or MISS.
//  Keeps a saturating score and combo, read by the display and scoreboard logic.
// PARAMETERS
//  PERFECT_TICKS  2   press with window count < PERFECT_TICKS grades PERFECT (1..GOOD_TICKS)
//  GOOD_TICKS     5   window length in ticks; reaching it unpressed grades MISS (>=1)
//  SCORE_W        16  width of score_o
//  COMBO_W        8   width of combo_o
// PORTS
//  clk_i         in   1        system clock (same clock as the beat timer)
//  rst_i         in   1        asynchronous, active-high reset
//  tick_i        in   1        1-cycle tick pulse from the beat timer
//  note_valid_i  in   1        1-cycle strobe: notes in note_lanes_i hit the target line now
//  note_lanes_i  in   4        lane mask of arriving notes, valid with note_valid_i
//  btn_i         in   4        synchronized, debounced lane buttons, level
//  perfect_o     out  4        per-lane 1-cycle PERFECT pulse
//  good_o        out  4        per-lane 1-cycle GOOD pulse
//  miss_o        out  4        per-lane 1-cycle MISS pulse
//  boo_o         out  4        per-lane 1-cycle stray-press pulse (BOO_PENALTY_EN only)
//  score_o       out  SCORE_W  accumulated score
//  combo_o       out  COMBO_W  current combo
// BEHAVIOUR
//  Reset (async, any time, including mid-window):
//   - all outputs 0, all lanes IDLE, window counters 0
//   - btn_prev = 4'b1111, so a button held through reset produces no edge
//  Edge detect: press[l] = btn_i[l] & ~btn_prev[l]; btn_prev <= btn_i every cycle.
//  Per-lane FSM, independent per lane:
//   - IDLE:  note_valid_i & note_lanes_i[l] -> ARMED, cnt=0
//   - ARMED: on press, grade from current cnt (pre-increment):
//       cnt < PERFECT_TICKS -> PERFECT; else -> GOOD; lane -> IDLE
//   - ARMED: no press, tick_i, cnt==GOOD_TICKS-1 -> MISS, lane -> IDLE
//   - ARMED: no press, tick_i otherwise -> cnt+1
//  Simultaneous events, per lane:
//   - press and expiring tick in the same cycle: the press wins (GOOD, or PERFECT if
//     PERFECT_TICKS==GOOD_TICKS)
//   - press on the note-arrival cycle while IDLE: PERFECT, lane stays IDLE
//   - new note while ARMED with no press: old note is MISS, lane re-arms with cnt=0
//   - new note while ARMED with press: old note graded by cnt, lane re-arms with cnt=0
//   - new note on the expiry cycle: MISS pulse, lane re-arms with cnt=0
//  Latency: grade pulses are registered and assert the cycle after the causing edge,
//   for exactly 1 cycle. score_o and combo_o update on that same edge.
//  Arithmetic, summing over all 4 lanes in one cycle:
//   - hits = #PERFECT + #GOOD; pts = 2*#PERFECT + 1*#GOOD
//   - score <= min(score + pts, 2^SCORE_W-1), saturating
//   - combo <= (any MISS) ? 0 : min(combo + hits, 2^COMBO_W-1)
// CONFIGURATION
//  BOO_PENALTY_EN defined:
//   - a press on an IDLE lane (with no note arriving that cycle) pulses boo_o[l]
//     the next cycle and forces combo to 0 that cycle
//   - score is unchanged by a BOO
//  BOO_PENALTY_EN undefined:
//   - stray presses are ignored; boo_o tied to 4'b0000
// TESTING (PERFECT_TICKS=2, GOOD_TICKS=5)
//  1. Note lane 0; press after 1 tick -> perfect_o=4'b0001 one cycle; score 0->2; combo 0->1.
//  2. Note lane 2; press after 3 ticks -> good_o=4'b0100; score +1; combo +1.
//  3. Note lane 3, no press; on 5th tick -> miss_o=4'b1000; combo 5->0; score unchanged.
//  4. Notes lanes 0+1 at once; both pressed at cnt=0 in the same cycle -> perfect_o=4'b0011;
//     score +4; combo +2. Press and 5th tick on the same cycle -> good_o, no miss_o.
//  5. Preload score=16'hFFFE, combo=8'hFF; PERFECT -> score=16'hFFFF, combo=8'hFF.
//     Assert rst_i mid-window -> all outputs 0; held btn_i after release -> no grade pulse.
//  6. Stray press on lane 1, combo=3: BOO_PENALTY_EN -> boo_o=4'b0010, combo=0;
//     without the macro -> no pulse, combo stays 3.

Source files
------------

// File: rtl/hit_judge.sv
// hit_judge: per-lane hit-window tracker and grader for the four DDR arrow lanes, with saturating score/combo.
// Optional macro BOO_PENALTY_EN: stray presses on idle lanes pulse boo_o and break the combo.

module hit_lane #(
    parameter int PERFECT_TICKS = 2,
    parameter int GOOD_TICKS    = 5,
    parameter int CNT_W         = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic note,
    input  logic press,
    output logic perfect,
    output logic good,
    output logic miss,
    output logic boo
);
    typedef enum logic {IDLE, ARMED} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               expire;

    assign expire = tick && (cnt == CNT_W'(GOOD_TICKS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // A press always beats an expiring tick; a new note always re-arms from zero.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        perfect   = 1'b0;
        good      = 1'b0;
        miss      = 1'b0;
        boo       = 1'b0;
        case (state)
            IDLE: begin
                if (note) begin
                    if (press) begin
                        perfect = 1'b1;
                    end else begin
                        state_nxt = ARMED;
                        cnt_nxt   = '0;
                    end
                end else if (press) begin
`ifdef BOO_PENALTY_EN
                    boo = 1'b1;
`endif
                end
            end
            ARMED: begin
                if (press) begin
                    if (cnt < CNT_W'(PERFECT_TICKS)) perfect = 1'b1;
                    else                             good    = 1'b1;
                    state_nxt = note ? ARMED : IDLE;
                    cnt_nxt   = '0;
                end else if (expire || note) begin
                    miss      = 1'b1;
                    state_nxt = note ? ARMED : IDLE;
                    cnt_nxt   = '0;
                end else if (tick) begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

module hit_judge #(
    parameter int PERFECT_TICKS = 2,
    parameter int GOOD_TICKS    = 5,
    parameter int SCORE_W       = 16,
    parameter int COMBO_W       = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               tick_i,
    input  logic               note_valid_i,
    input  logic [3:0]         note_lanes_i,
    input  logic [3:0]         btn_i,
    output logic [3:0]         perfect_o,
    output logic [3:0]         good_o,
    output logic [3:0]         miss_o,
    output logic [3:0]         boo_o,
    output logic [SCORE_W-1:0] score_o,
    output logic [COMBO_W-1:0] combo_o
);
    localparam int NUM_LANES = 4;
    localparam int CNT_W     = $clog2(GOOD_TICKS + 1);

    logic [NUM_LANES-1:0] btn_prev, press, note_hit;
    logic [NUM_LANES-1:0] perf_c, good_c, miss_c, boo_c;
    logic [2:0]           n_perf, n_good, hits;
    logic [3:0]           pts;
    logic [SCORE_W:0]     score_sum;
    logic [COMBO_W:0]     combo_sum;
    logic [SCORE_W-1:0]   score_nxt;
    logic [COMBO_W-1:0]   combo_nxt;

    assign press    = btn_i & ~btn_prev;
    assign note_hit = note_lanes_i & {NUM_LANES{note_valid_i}};

    hit_lane #(
        .PERFECT_TICKS (PERFECT_TICKS),
        .GOOD_TICKS    (GOOD_TICKS),
        .CNT_W         (CNT_W)
    ) u_lane [NUM_LANES-1:0] (
        .clk     (clk_i),
        .rst     (rst_i),
        .tick    (tick_i),
        .note    (note_hit),
        .press   (press),
        .perfect (perf_c),
        .good    (good_c),
        .miss    (miss_c),
        .boo     (boo_c)
    );

    always_comb begin
        n_perf = '0;
        n_good = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            n_perf = n_perf + 3'(perf_c[l]);
            n_good = n_good + 3'(good_c[l]);
        end
        hits      = n_perf + n_good;
        pts       = {n_perf, 1'b0} + {1'b0, n_good};
        // One spare bit catches the overflow that triggers saturation.
        score_sum = {1'b0, score_o} + (SCORE_W+1)'(pts);
        combo_sum = {1'b0, combo_o} + (COMBO_W+1)'(hits);
        score_nxt = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
        if (|miss_c || |boo_c)
            combo_nxt = '0;
        else
            combo_nxt = combo_sum[COMBO_W] ? '1 : combo_sum[COMBO_W-1:0];
    end

    // btn_prev resets high so a button held through reset is not seen as a press.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            btn_prev  <= '1;
            perfect_o <= '0;
            good_o    <= '0;
            miss_o    <= '0;
            boo_o     <= '0;
            score_o   <= '0;
            combo_o   <= '0;
        end else begin
            btn_prev  <= btn_i;
            perfect_o <= perf_c;
            good_o    <= good_c;
            miss_o    <= miss_c;
            boo_o     <= boo_c;
            score_o   <= score_nxt;
            combo_o   <= combo_nxt;
        end
    end
endmodule

// File: tb/tb_hit_judge.sv
// Bench for hit_judge: directed vector table, random stimulus against a lane-level reference model,
// score saturation and mid-window reset sequences.
module tb_hit_judge;
    localparam int PT = 2;
    localparam int GT = 5;
    localparam int SW = 16;
    localparam int CW = 8;
`ifdef BOO_PENALTY_EN
    localparam bit BOO_EN = 1'b1;
`else
    localparam bit BOO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tick = 1'b0;
    logic          nv = 1'b0;
    logic [3:0]    lanes = 4'h0;
    logic [3:0]    btn = 4'hF;
    logic [3:0]    perfect_o, good_o, miss_o, boo_o;
    logic [SW-1:0] score_o;
    logic [CW-1:0] combo_o;

    always #5 clk = ~clk;

    hit_judge #(.PERFECT_TICKS(PT), .GOOD_TICKS(GT), .SCORE_W(SW), .COMBO_W(CW)) dut (
        .clk_i(clk), .rst_i(rst), .tick_i(tick), .note_valid_i(nv), .note_lanes_i(lanes),
        .btn_i(btn), .perfect_o(perfect_o), .good_o(good_o), .miss_o(miss_o), .boo_o(boo_o),
        .score_o(score_o), .combo_o(combo_o)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: each lane is "waiting for a note" or "holding a note of some age in ticks".
    bit         m_armed [4];
    int         m_age   [4];
    logic [3:0] m_prev;
    int         m_score, m_combo;
    logic [3:0] e_perf, e_good, e_miss, e_boo;

    function void model_reset();
        for (int l = 0; l < 4; l++) begin
            m_armed[l] = 1'b0;
            m_age[l]   = 0;
        end
        m_prev  = 4'hF;
        m_score = 0;
        m_combo = 0;
    endfunction

    function void model_step(bit t, bit v, logic [3:0] ln, logic [3:0] b);
        logic [3:0] pr;
        bit         n;
        int         np, ng;
        pr = b & ~m_prev;
        m_prev = b;
        e_perf = 0; e_good = 0; e_miss = 0; e_boo = 0;
        for (int l = 0; l < 4; l++) begin
            n = v && ln[l];
            if (m_armed[l]) begin
                if (pr[l]) begin
                    if (m_age[l] < PT) e_perf[l] = 1'b1;
                    else               e_good[l] = 1'b1;
                    m_armed[l] = n;
                    m_age[l]   = 0;
                end else if (n || (t && m_age[l] == GT - 1)) begin
                    e_miss[l]  = 1'b1;
                    m_armed[l] = n;
                    m_age[l]   = 0;
                end else if (t) begin
                    m_age[l] = m_age[l] + 1;
                end
            end else if (n) begin
                if (pr[l]) e_perf[l] = 1'b1;
                else begin
                    m_armed[l] = 1'b1;
                    m_age[l]   = 0;
                end
            end else if (pr[l] && BOO_EN) begin
                e_boo[l] = 1'b1;
            end
        end
        np = $countones(e_perf);
        ng = $countones(e_good);
        m_score = (m_score + 2*np + ng > 2**SW - 1) ? 2**SW - 1 : m_score + 2*np + ng;
        if (e_miss != 0 || e_boo != 0) m_combo = 0;
        else m_combo = (m_combo + np + ng > 2**CW - 1) ? 2**CW - 1 : m_combo + np + ng;
    endfunction

    task automatic check(string nm, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic cyc(bit t, bit v, logic [3:0] ln, logic [3:0] b);
        tick = t; nv = v; lanes = ln; btn = b;
        model_step(t, v, ln, b);
        @(posedge clk);
        #1;
        tick = 1'b0; nv = 1'b0;
    endtask

    task automatic check_model(string nm);
        check({nm, ".perf"},  perfect_o, e_perf);
        check({nm, ".good"},  good_o,    e_good);
        check({nm, ".miss"},  miss_o,    e_miss);
        check({nm, ".boo"},   boo_o,     e_boo);
        check({nm, ".score"}, score_o,   m_score);
        check({nm, ".combo"}, combo_o,   m_combo);
    endtask

    task automatic check_zero(string nm);
        check({nm, ".perf"},  perfect_o, 0);
        check({nm, ".good"},  good_o,    0);
        check({nm, ".miss"},  miss_o,    0);
        check({nm, ".boo"},   boo_o,     0);
        check({nm, ".score"}, score_o,   0);
        check({nm, ".combo"}, combo_o,   0);
    endtask

    typedef struct {
        bit         t;
        bit         v;
        logic [3:0] ln, b, perf, good, miss, boo;
        int         score, combo;
    } vec_t;
    vec_t tbl[$];

    function void add(bit t, bit v, logic [3:0] ln, logic [3:0] b, logic [3:0] p, logic [3:0] g,
                      logic [3:0] m, logic [3:0] bo, int s, int c);
        vec_t r;
        r.t = t; r.v = v; r.ln = ln; r.b = b; r.perf = p; r.good = g; r.miss = m; r.boo = bo;
        r.score = s; r.combo = c;
        tbl.push_back(r);
    endfunction

    initial begin
        logic [3:0] rb;
        int         stray_combo;
        stray_combo = BOO_EN ? 0 : 3;

        // lane 0 perfect after 1 tick
        add(0,1,4'h1,4'h0, 0,0,0,0, 0,0);
        add(1,0,4'h0,4'h0, 0,0,0,0, 0,0);
        add(0,0,4'h0,4'h1, 4'h1,0,0,0, 2,1);
        add(0,0,4'h0,4'h0, 0,0,0,0, 2,1);
        // lane 2 good after 3 ticks
        add(0,1,4'h4,4'h0, 0,0,0,0, 2,1);
        for (int i = 0; i < 3; i++) add(1,0,4'h0,4'h0, 0,0,0,0, 2,1);
        add(0,0,4'h0,4'h4, 0,4'h4,0,0, 3,2);
        add(0,0,4'h0,4'h0, 0,0,0,0, 3,2);
        // lanes 0+1 pressed together at cnt 0
        add(0,1,4'h3,4'h0, 0,0,0,0, 3,2);
        add(0,0,4'h0,4'h3, 4'h3,0,0,0, 7,4);
        add(0,0,4'h0,4'h0, 0,0,0,0, 7,4);
        // press on the expiring tick
        add(0,1,4'h1,4'h0, 0,0,0,0, 7,4);
        for (int i = 0; i < 4; i++) add(1,0,4'h0,4'h0, 0,0,0,0, 7,4);
        add(1,0,4'h0,4'h1, 0,4'h1,0,0, 8,5);
        add(0,0,4'h0,4'h0, 0,0,0,0, 8,5);
        // lane 3 miss on 5th tick
        add(0,1,4'h8,4'h0, 0,0,0,0, 8,5);
        for (int i = 0; i < 4; i++) add(1,0,4'h0,4'h0, 0,0,0,0, 8,5);
        add(1,0,4'h0,4'h0, 0,0,4'h8,0, 8,0);
        add(0,0,4'h0,4'h0, 0,0,0,0, 8,0);
        // new note while armed: miss then re-arm
        add(0,1,4'h2,4'h0, 0,0,0,0, 8,0);
        add(0,1,4'h2,4'h0, 0,0,4'h2,0, 8,0);
        add(0,0,4'h0,4'h2, 4'h2,0,0,0, 10,1);
        add(0,0,4'h0,4'h0, 0,0,0,0, 10,1);
        // press on arrival cycle while idle
        add(0,1,4'h1,4'h1, 4'h1,0,0,0, 12,2);
        add(0,0,4'h0,4'h0, 0,0,0,0, 12,2);
        add(0,1,4'h1,4'h1, 4'h1,0,0,0, 14,3);
        add(0,0,4'h0,4'h0, 0,0,0,0, 14,3);
        // stray press on lane 1
        add(0,0,4'h0,4'h2, 0,0,0,BOO_EN ? 4'h2 : 4'h0, 14,stray_combo);
        add(0,0,4'h0,4'h0, 0,0,0,0, 14,stray_combo);
        // new note on the expiry cycle
        add(0,1,4'h1,4'h0, 0,0,0,0, 14,stray_combo);
        for (int i = 0; i < 4; i++) add(1,0,4'h0,4'h0, 0,0,0,0, 14,stray_combo);
        add(1,1,4'h1,4'h0, 0,0,4'h1,0, 14,0);
        add(0,0,4'h0,4'h1, 4'h1,0,0,0, 16,1);
        add(0,0,4'h0,4'h0, 0,0,0,0, 16,1);

        // reset state
        #3;
        check_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();

        foreach (tbl[i]) begin
            cyc(tbl[i].t, tbl[i].v, tbl[i].ln, tbl[i].b);
            check($sformatf("v%0d.perf", i),  perfect_o, tbl[i].perf);
            check($sformatf("v%0d.good", i),  good_o,    tbl[i].good);
            check($sformatf("v%0d.miss", i),  miss_o,    tbl[i].miss);
            check($sformatf("v%0d.boo", i),   boo_o,     tbl[i].boo);
            check($sformatf("v%0d.score", i), score_o,   tbl[i].score);
            check($sformatf("v%0d.combo", i), combo_o,   tbl[i].combo);
        end

        // random stimulus against the model
        rb = 4'h0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) rb = rb ^ 4'($urandom);
            cyc($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0, 4'($urandom), rb);
            check_model($sformatf("rnd%0d", i));
        end

        // score saturation
        rst = 1'b1; btn = 4'hF;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 8191; i++) begin
            cyc(0, 0, 4'h0, 4'h0);
            cyc(0, 1, 4'hF, 4'hF);
        end
        cyc(0, 0, 4'h0, 4'h0);
        cyc(0, 1, 4'h7, 4'h7);
        check("sat.score_fffe", score_o, 32'hFFFE);
        check("sat.combo_ff",   combo_o, 32'hFF);
        cyc(0, 0, 4'h0, 4'h0);
        cyc(0, 1, 4'h1, 4'h1);
        check("sat.perf",       perfect_o, 32'h1);
        check("sat.score_ffff", score_o, 32'hFFFF);
        check("sat.combo_hold", combo_o, 32'hFF);
        cyc(0, 0, 4'h0, 4'h0);
        cyc(0, 1, 4'hF, 4'hF);
        check_model("sat.again");

        // asynchronous reset mid-window with buttons held
        cyc(0, 0, 4'h0, 4'h0);
        cyc(0, 1, 4'hF, 4'h0);
        cyc(1, 0, 4'h0, 4'h0);
        btn = 4'hF;
        rst = 1'b1;
        #1;
        check_zero("midrst");
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 6; i++) begin
            cyc(1, 0, 4'h0, 4'hF);
            check_model($sformatf("held%0d", i));
        end
        check("held.no_miss", miss_o, 32'h0);
        cyc(0, 0, 4'h0, 4'h0);
        check_model("release");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
